// File: rtl/bsg_mux_one_hot_rr_buffered.sv
// Arbitrating valid/ready mux: a one-hot grant (round-robin or external) loads one output
// register, giving one transfer per cycle, 1-cycle latency and a sticky multi-hot select error.
module bsg_mux_one_hot_rr_buffered #(
   parameter int width_p   = 8,  // every instantiation overrides this with its word width
   parameter int els_p     = 4,
   parameter int ext_sel_p = 0,
   localparam int tag_w_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
   input  logic                            clk_i,
   input  logic                            reset_n_i,
   input  logic [els_p-1:0]                v_i,
   input  logic [els_p-1:0][width_p-1:0]   data_i,
   output logic [els_p-1:0]                ready_o,
   input  logic [els_p-1:0]                sel_one_hot_i,
   output logic                            v_o,
   output logic [width_p-1:0]              data_o,
   output logic [tag_w_lp-1:0]             tag_o,
   input  logic                            ready_i,
   output logic                            err_o
);

   logic [els_p-1:0]    rr_grant, ext_grant, grant;
   logic [tag_w_lp-1:0] rr_idx, ext_idx, grant_idx, scan_idx;
   logic                rr_found, sel_multi_hot, can_accept, load;

   logic                v_q, v_d;
   logic [width_p-1:0]  data_q, data_d;
   logic [tag_w_lp-1:0] tag_q, tag_d, last_q, last_d;
   logic                err_q, err_d;

   // Scan starts just after the last winner and wraps, so a waiting requester loses at most els_p-1 grants.
   // NOTE: combinational blocks use blocking '=' with a default for every output first, so no latch is inferred.
   always_comb begin
      rr_grant = '0;
      rr_idx   = '0;
      rr_found = 1'b0;
      scan_idx = '0;
      for (int k = 1; k <= els_p; k++) begin
         scan_idx = tag_w_lp'((int'(last_q) + k) % els_p);
         if (!rr_found && v_i[scan_idx]) begin
            rr_found           = 1'b1;
            rr_grant[scan_idx] = 1'b1;
            rr_idx             = scan_idx;
         end
      end
   end

   assign sel_multi_hot = |(sel_one_hot_i & (sel_one_hot_i - els_p'(1)));

   always_comb begin
      ext_grant = sel_multi_hot ? '0 : (sel_one_hot_i & v_i);
      ext_idx   = '0;
      for (int i = 0; i < els_p; i++) begin
         if (ext_grant[i]) ext_idx = tag_w_lp'(i);
      end
   end

   assign grant     = (ext_sel_p != 0) ? ext_grant : rr_grant;
   assign grant_idx = (ext_sel_p != 0) ? ext_idx   : rr_idx;

   // Nothing is offered to the inputs while reset is held.
   assign can_accept = reset_n_i & (~v_q | ready_i);
   assign load       = (|grant) & can_accept;
   assign ready_o    = grant & {els_p{can_accept}};

   always_comb begin
      v_d    = v_q;
      data_d = data_q;
      tag_d  = tag_q;
      last_d = last_q;
      err_d  = err_q | ((ext_sel_p != 0) & sel_multi_hot & (|v_i));
      if (load) begin
         v_d    = 1'b1;
         data_d = data_i[grant_idx];
         tag_d  = grant_idx;
         if (ext_sel_p == 0) last_d = grant_idx;
      end else if (ready_i) begin
         v_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking '<=' and are all cleared by the async reset,
   // including the data word, so data_o reads 0 after reset.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         v_q    <= 1'b0;
         data_q <= '0;
         tag_q  <= '0;
         last_q <= tag_w_lp'(els_p - 1);
         err_q  <= 1'b0;
      end else begin
         v_q    <= v_d;
         data_q <= data_d;
         tag_q  <= tag_d;
         last_q <= last_d;
         err_q  <= err_d;
      end
   end

   assign v_o    = v_q;
   assign data_o = data_q;
   assign tag_o  = tag_q;
   assign err_o  = err_q;

endmodule

// File: tb/tb_bsg_mux_one_hot_rr_buffered.sv
// Self-checking bench: directed vector table, hand-written stall/reset/external-select
// sequences, and a randomized run against a queue-based reference model.
module tb_bsg_mux_one_hot_rr_buffered;

   localparam int N = 4;

   logic clk_i, reset_n_i;

   // round-robin instance
   logic [N-1:0]       r_v, r_sel, r_ready_o;
   logic [N-1:0][15:0] r_data;
   logic               r_rdy, r_vo, r_err;
   logic [15:0]        r_do;
   logic [1:0]         r_tag;

   // external-select instance
   logic [N-1:0]       e_v, e_sel, e_ready_o;
   logic [N-1:0][7:0]  e_data;
   logic               e_rdy, e_vo, e_err;
   logic [7:0]         e_do;
   logic [1:0]         e_tag;

   bsg_mux_one_hot_rr_buffered #(.width_p(16), .els_p(N), .ext_sel_p(0)) dut_rr (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(r_v), .data_i(r_data), .ready_o(r_ready_o),
      .sel_one_hot_i(r_sel), .v_o(r_vo), .data_o(r_do), .tag_o(r_tag), .ready_i(r_rdy),
      .err_o(r_err));

   bsg_mux_one_hot_rr_buffered #(.width_p(8), .els_p(N), .ext_sel_p(1)) dut_ext (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(e_v), .data_i(e_data), .ready_o(e_ready_o),
      .sel_one_hot_i(e_sel), .v_o(e_vo), .data_o(e_do), .tag_o(e_tag), .ready_i(e_rdy),
      .err_o(e_err));

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   typedef struct packed {
      logic [3:0] v;
      logic       rdy;
      logic [3:0] exp_ready;
      logic       exp_vo;
      logic [1:0] exp_tag;
   } vec_t;

   vec_t vecs [14];

   // reference model state for the randomized run
   logic [15:0] chan_q [N][$];
   logic        pend [N];
   logic [15:0] pend_word [N];
   int          seq [N];
   int          wait_cnt [N];
   logic        m_v;
   logic [15:0] m_data;
   logic [1:0]  m_tag;
   int          m_last;

   task automatic consume();
      logic [15:0] want;
      if (r_vo && r_rdy) begin
         if (chan_q[r_tag].size() > 0) begin
            want = chan_q[r_tag].pop_front();
            check("rand_order", r_do, want);
         end else begin
            check("rand_dup_qlen", chan_q[r_tag].size(), 1);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int g, best, d;
      logic       can;
      logic [3:0] exp_ready;
      int         left;

      vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
      vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
      vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
      vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
      vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
      vecs[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
      vecs[6]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd0};
      vecs[7]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
      vecs[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2};
      vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2};
      vecs[10] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1};
      vecs[11] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};
      vecs[12] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0};
      vecs[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

      // reset held with every channel requesting
      reset_n_i = 1'b1;
      r_v = 4'b1111; r_sel = '0; r_rdy = 1'b1;
      e_v = 4'b1111; e_sel = '0; e_rdy = 1'b1;
      for (int i = 0; i < N; i++) begin
         r_data[i] = 16'h00A0 + 16'(i);
         e_data[i] = 8'h30 + 8'(i);
      end
      #2 reset_n_i = 1'b0;
      #20;
      check("rst_vo",       r_vo, 0);
      check("rst_data",     r_do, 0);
      check("rst_tag",      r_tag, 0);
      check("rst_ready",    r_ready_o, 0);
      check("rst_err",      r_err, 0);
      check("rst_ext_ready", e_ready_o, 0);
      check("rst_ext_err",  e_err, 0);
      @(posedge clk_i);
      #1;
      reset_n_i = 1'b1;
      r_v = '0; e_v = '0;

      // vector table: rr sequence, stall, drain, sparse wrap
      for (int i = 0; i < 14; i++) begin
         r_v   = vecs[i].v;
         r_rdy = vecs[i].rdy;
         #1;
         check($sformatf("vec%0d_ready", i), r_ready_o, vecs[i].exp_ready);
         tick();
         check($sformatf("vec%0d_vo_tag", i), {r_vo, r_tag}, {vecs[i].exp_vo, vecs[i].exp_tag});
         check($sformatf("vec%0d_data", i), r_do, 16'h00A0 + 16'(vecs[i].exp_tag));
      end

      // backpressure: 5 stalled cycles, then same-cycle drain+load
      r_v = 4'b0010; r_rdy = 1'b0;
      #1;
      check("bp_load_ready", r_ready_o, 4'b0010);
      tick();
      check("bp_loaded", {r_vo, r_tag, r_do}, {1'b1, 2'd1, 16'h00A1});
      for (int c = 0; c < 5; c++) begin
         r_v = 4'b1111; r_rdy = 1'b0;
         r_data = {$urandom, $urandom};
         #1;
         check($sformatf("bp_stall%0d_ready", c), r_ready_o, 0);
         tick();
         check($sformatf("bp_stall%0d_hold", c), {r_vo, r_tag, r_do}, {1'b1, 2'd1, 16'h00A1});
      end
      r_v = 4'b0100; r_rdy = 1'b1; r_data[2] = 16'h1234;
      #1;
      check("bp_release_ready", r_ready_o, 4'b0100);
      tick();
      check("bp_no_bubble", {r_vo, r_tag, r_do}, {1'b1, 2'd2, 16'h1234});

      // async reset mid-stream, sampled before any clock edge
      r_v = '0; r_rdy = 1'b0;
      #2 reset_n_i = 1'b0;
      #1;
      check("async_rst_vo",   r_vo, 0);
      check("async_rst_data", r_do, 0);
      tick();
      reset_n_i = 1'b1;

      // external select
      e_data[0] = 8'h3E; e_data[1] = 8'h11; e_data[2] = 8'h5C; e_data[3] = 8'h77;
      e_rdy = 1'b1;
      e_sel = 4'b0011; e_v = 4'b0000;
      #1;
      check("ext_mh_novalid_ready", e_ready_o, 0);
      tick();
      check("ext_mh_novalid_err", {e_err, e_vo}, 2'b00);
      e_sel = 4'b1000; e_v = 4'b0110;
      #1;
      check("ext_sel_notvalid_ready", e_ready_o, 0);
      tick();
      check("ext_sel_notvalid_out", {e_err, e_vo}, 2'b00);
      e_sel = 4'b0100; e_v = 4'b0110;
      #1;
      check("ext_onehot_ready", e_ready_o, 4'b0100);
      tick();
      check("ext_onehot_out", {e_err, e_vo, e_tag, e_do}, {1'b0, 1'b1, 2'd2, 8'h5C});
      e_sel = 4'b0110;
      #1;
      check("ext_multihot_ready", e_ready_o, 0);
      tick();
      check("ext_multihot_err", {e_err, e_vo}, 2'b10);
      e_sel = 4'b0000;
      #1;
      check("ext_zero_ready", e_ready_o, 0);
      tick();
      check("ext_zero_err", {e_err, e_vo}, 2'b10);
      e_sel = 4'b0001; e_v = 4'b0001;
      #1;
      check("ext_after_err_ready", e_ready_o, 4'b0001);
      tick();
      check("ext_after_err_out", {e_err, e_vo, e_tag, e_do}, {1'b1, 1'b1, 2'd0, 8'h3E});
      e_v = '0; e_sel = '0;

      // randomized run against the reference model
      reset_n_i = 1'b0;
      tick();
      reset_n_i = 1'b1;
      m_v = 1'b0; m_data = '0; m_tag = '0; m_last = N - 1;
      for (int ch = 0; ch < N; ch++) begin
         pend[ch] = 1'b0; seq[ch] = 0; wait_cnt[ch] = 0;
      end
      for (int cyc = 0; cyc < 10000; cyc++) begin
         check("rand_out", {r_vo, r_tag, r_do}, {m_v, m_tag, m_data});
         for (int ch = 0; ch < N; ch++) begin
            if (!pend[ch] && $urandom_range(0, 1) == 1) begin
               pend[ch]      = 1'b1;
               pend_word[ch] = {4'(ch), 12'(seq[ch])};
               seq[ch]++;
            end
            r_v[ch]    = pend[ch];
            r_data[ch] = pend[ch] ? pend_word[ch] : 16'($urandom);
         end
         r_rdy = ($urandom_range(0, 3) != 0);
         #1;
         can  = !m_v || r_rdy;
         g    = -1;
         best = N;
         for (int ch = 0; ch < N; ch++) begin
            d = (ch - m_last - 1 + 2 * N) % N;
            if (pend[ch] && d < best) begin
               best = d;
               g    = ch;
            end
         end
         exp_ready = (can && g >= 0) ? 4'(1 << g) : 4'b0000;
         check("rand_ready", r_ready_o, exp_ready);
         consume();
         for (int ch = 0; ch < N; ch++) begin
            if (r_v[ch] && r_ready_o[ch]) begin
               check("rand_starvation", wait_cnt[ch] <= N - 1, 1);
               chan_q[ch].push_back(r_data[ch]);
               pend[ch]     = 1'b0;
               wait_cnt[ch] = 0;
               for (int o = 0; o < N; o++) begin
                  if (o != ch && pend[o]) wait_cnt[o]++;
               end
            end
         end
         if (can && g >= 0) begin
            m_v = 1'b1; m_data = r_data[g]; m_tag = 2'(g); m_last = g;
         end else if (m_v && r_rdy) begin
            m_v = 1'b0;
         end
         tick();
      end
      r_v = '0; r_rdy = 1'b1;
      #1;
      consume();
      tick();
      left = 0;
      for (int ch = 0; ch < N; ch++) left += chan_q[ch].size();
      check("rand_no_loss", left, 0);
      check("rand_drained", r_vo, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
